// File: rtl/lpif_ll_pkg.sv
// Shared types and constants for the LPIF logic-link transmit credit stage.
package lpif_ll_pkg;

  localparam int LL_CREDIT_W      = 8;
  localparam int LL_DEFAULT_WIDTH = 42;

  typedef enum logic [1:0] {
    LL_OFFLINE = 2'd0,
    LL_ACTIVE  = 2'd1,
    LL_DRAIN   = 2'd2
  } ll_tx_state_e;

endpackage

// File: rtl/lpif_ll_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; read data is shown combinationally at the head.
module lpif_ll_sync_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage is not reset: pointer reset alone discards the contents.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/lpif_ll_tx_credit.sv
// Logic-link transmit stage: buffers packed packer words and sends them against link credits.
// Optional LPIF_LL_TX_IDLE_DROP_EN: idle words (MSB clear) are accepted but never stored or sent.
module lpif_ll_tx_credit
  import lpif_ll_pkg::*;
#(
  parameter int WIDTH        = LL_DEFAULT_WIDTH,
  parameter int DEPTH        = 8,
  parameter int INIT_CREDITS = 8
) (
  input  logic                     clk_wr,
  input  logic                     rst_wr_n,
  input  logic [WIDTH-1:0]         txfifo_downstream_data,
  input  logic                     txfifo_downstream_push,
  output logic                     txfifo_downstream_ready,
  output logic [WIDTH-1:0]         ll_tx_data,
  output logic                     ll_tx_valid,
  input  logic                     tx_online,
  input  logic                     rx_credit_return,
  output logic [LL_CREDIT_W-1:0]   tx_credit_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow_err,
  output logic                     credit_err,
  output ll_tx_state_e             tx_state
);

  // Handshake: a word moves into the FIFO on any clk_wr edge where push and ready are both 1;
  // the link side has no backpressure, ll_tx_valid marks exactly one word per cycle.

  localparam logic [LL_CREDIT_W-1:0] INIT_C     = LL_CREDIT_W'(INIT_CREDITS);
  localparam logic [LL_CREDIT_W-1:0] CREDIT_ONE = {{(LL_CREDIT_W-1){1'b0}}, 1'b1};

  ll_tx_state_e           state_q, state_d;
  logic [LL_CREDIT_W-1:0] credit_q;
  logic [WIDTH-1:0]       fifo_rdata;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                   send, idle_word;

`ifdef LPIF_LL_TX_IDLE_DROP_EN
  assign idle_word = ~txfifo_downstream_data[WIDTH-1];
`else
  assign idle_word = 1'b0;
`endif

  // Ready comes from the registered level, so a push on a full FIFO is refused even if a pop happens.
  assign txfifo_downstream_ready = (state_q == LL_ACTIVE) && !fifo_full;
  assign fifo_push = txfifo_downstream_push && txfifo_downstream_ready && !idle_word;
  assign send      = (state_q == LL_ACTIVE) && !fifo_empty && (credit_q != '0);
  assign fifo_pop  = send || ((state_q == LL_DRAIN) && !fifo_empty);

  assign tx_credit_count = credit_q;
  assign tx_state        = state_q;

  lpif_ll_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_wr),
    .rst_n (rst_wr_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (txfifo_downstream_data),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LL_OFFLINE: if (tx_online)         state_d = LL_ACTIVE;
      LL_ACTIVE:  if (!tx_online)        state_d = LL_DRAIN;
      LL_DRAIN:   if (fifo_level == '0)  state_d = LL_OFFLINE;
      default:                           state_d = LL_OFFLINE;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q      <= LL_OFFLINE;
      credit_q     <= '0;
      ll_tx_valid  <= 1'b0;
      ll_tx_data   <= '0;
      overflow_err <= 1'b0;
      credit_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ll_tx_valid <= send;
      if (send) ll_tx_data <= fifo_rdata;
      if (txfifo_downstream_push && !txfifo_downstream_ready && !idle_word) overflow_err <= 1'b1;
      // Credits are zero whenever offline, loaded on link-up, and frozen while draining.
      if (state_d == LL_OFFLINE) begin
        credit_q <= '0;
      end else if (state_q == LL_OFFLINE) begin
        credit_q <= INIT_C;
      end else if (state_q == LL_ACTIVE) begin
        if (send && !rx_credit_return) begin
          credit_q <= credit_q - CREDIT_ONE;
        end else if (rx_credit_return && !send) begin
          if (credit_q == INIT_C) credit_err <= 1'b1;
          else                    credit_q   <= credit_q + CREDIT_ONE;
        end
      end
    end
  end

endmodule
